data_sram_responder: RTL
========================

# data_sram_responder

Memory-side responder for the pipeline's data SRAM port. It accepts load/store requests on the req/addr_ok handshake, performs them on an internal word-addressed array, and returns in-order responses on data_ok/rdata after a fixed latency. It is the far end of the interface that the EX stage drives and the MEM stage consumes. It serves as the data memory model in the core's simulation top and as a drop-in synchronous data RAM.

## Interface
Parameters:
- ADDR_WIDTH, 12: word-index bits; array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: cycles from request acceptance edge to the data_ok cycle; legal range 1..7.
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests; legal range 1..8, must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, not used for lane selection.
- data_sram_wstrb  in  4  byte-lane write enables for stores.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  store data, lane-aligned.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
- data_sram_data_ok  out  1  one-cycle response pulse, one per accepted request.
- data_sram_rdata  out  32  load data; valid only while data_ok is high.

## Operation
- Word index = addr[ADDR_WIDTH+1:2]. addr[1:0] and the bits above ADDR_WIDTH+1 are ignored, so addresses alias.
- Acceptance occurs at a rising edge where req && addr_ok.
- Stores: each byte lane i with wstrb[i]=1 is written at the acceptance edge. A store with wstrb=0 writes nothing but still gets a response.
- Loads: the array word is captured into the response queue at the acceptance edge.
- A load accepted after a store to the same word sees the store. A store accepted on the same edge as an earlier load does not affect that load.
- Response queue: circular FIFO of DEPTH entries. Each entry holds {is_load, rdata, countdown}.
  - On push, countdown is loaded with LATENCY-1 and decrements each cycle while nonzero.
  - The head is complete when its countdown is 0.
- data_ok = queue non-empty && head complete. rdata = head rdata for loads, 32'h0 for stores and whenever data_ok is low.
- The head pops at the edge ending a data_ok cycle. The receiver cannot stall responses.
- addr_ok = !reset && (count < DEPTH || data_ok). A simultaneous pop and push is allowed when full.
- Responses are strictly in acceptance order. Constant latency guarantees at most one completed entry per cycle.

## Timing
- Request accepted at edge k produces data_ok high during the cycle following edge k+LATENCY-1, and pops at edge k+LATENCY.
- LATENCY=1 with DEPTH≥1 sustains one request per cycle. In general, full throughput requires DEPTH ≥ LATENCY. Otherwise addr_ok drops when count reaches DEPTH.
- Reset values: addr_ok 0 while reset is high and 1 after release (queue empty), data_ok 0, rdata 32'h0, count 0, pointers 0.
- Reset asserted mid-operation: the queue is flushed immediately and pending responses are dropped (no data_ok). Stores already accepted remain in the array. Array contents are never reset.
- Wrap-around: read and write pointers wrap modulo DEPTH. count ranges 0..DEPTH and never overflows, because a push while full requires a simultaneous pop.
- A req held high with addr_ok low is not accepted. The requester must hold its fields stable until acceptance; the responder does not check this.

## Configuration
- RANDOM_STALL_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset value 16'hACE1) advances every cycle.
  - addr_ok is additionally forced low in any cycle where lfsr[0]=1, for bench backpressure.
  - Responses are unaffected.
- RANDOM_STALL_EN undefined: no LFSR logic, and addr_ok depends only on occupancy and data_ok.

## Test plan
- Reset release, idle: addr_ok=1, data_ok=0, rdata=0 for 10 cycles.
- Store wstrb=4'hF, addr 0x100, wdata 0xDEADBEEF, then load 0x100 (LATENCY=2): data_ok on the 2nd cycle after each acceptance; load returns 0xDEADBEEF; store response rdata=0.
- Byte store wstrb=4'b0100, wdata 0x00AA0000 to 0x100, then load 0x100 → 0xDEAABEEF.
- Back-to-back loads every cycle, LATENCY=2, DEPTH=2: addr_ok stays 1 and data_ok is high every cycle after a 2-cycle fill. DEPTH=1: addr_ok alternates, giving one accept per 2 cycles.
- Addresses 0x0 and 0x4000 (ADDR_WIDTH=12) alias: a store to 0x4000 value 0x12345678 is read back at 0x0.
- Reset asserted with 2 loads outstanding: no data_ok follows. A subsequent load of a previously stored word returns the stored value.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word-addressed RAM behind a req/addr_ok, data_ok/rdata handshake
// with fixed response latency and an in-order response queue. Optional macro: RANDOM_STALL_EN.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [2:0]    CD_INIT   = 3'(LATENCY - 1);

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  q_load [DEPTH];
  logic [31:0]           q_data [DEPTH];
  logic [2:0]            q_cd   [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept, head_done, stall;
  logic                  unused_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign idx         = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  assign head_done         = (count != '0) && (q_cd[rd_ptr] == 3'd0);
  assign data_sram_data_ok = head_done;
  assign data_sram_rdata   = (head_done && q_load[rd_ptr]) ? q_data[rd_ptr] : 32'h0;
  // A full queue can still accept when the head leaves on the same edge.
  assign data_sram_addr_ok = !reset && !stall && ((count < DEPTH_CNT) || head_done);
  assign accept            = data_sram_req && data_sram_addr_ok;

`ifdef RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Array contents survive reset; only accepted stores modify them.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_load[i] <= 1'b0;
        q_data[i] <= 32'h0;
        q_cd[i]   <= 3'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_cd[i] != 3'd0) begin
          q_cd[i] <= q_cd[i] - 3'd1;
        end
      end
      // The load value is sampled before any store on this edge lands.
      if (accept) begin
        q_load[wr_ptr] <= !data_sram_wr;
        q_data[wr_ptr] <= data_sram_wr ? 32'h0 : mem[idx];
        q_cd[wr_ptr]   <= CD_INIT;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (head_done) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({accept, head_done})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
